// File: rtl/add_sub_lanes_if.sv
// Request/response bundle for add_sub_lanes; master issues requests, slave returns results.
// No backpressure: a request to an occupied or nonexistent lane is rejected via err.
interface add_sub_lanes_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
);
  localparam int SELW = (LANES > 1) ? $clog2(LANES) : 1;

  logic             start;
  logic [SELW-1:0]  lane_sel;
  logic [1:0]       op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [LANES-1:0] busy;
  logic             err;
  logic             done;
  logic [SELW-1:0]  done_lane;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;

  modport master (
    output start, lane_sel, op, op1, op2,
    input  busy, err, done, done_lane, res, cout, ovf
  );

  modport slave (
    input  start, lane_sel, op, op1, op2,
    output busy, err, done, done_lane, res, cout, ovf
  );
endinterface

// File: rtl/add_sub_lanes.sv
// Multi-lane add/sub/compare unit: fixed LAT-cycle latency from accepted start to done.
// No stall path: requests to a busy or out-of-range lane are dropped and flagged by an err pulse.
module add_sub_lanes #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int LAT   = 2
) (
  input logic            clk,
  input logic            rst,
  add_sub_lanes_if.slave bus
);
  localparam int SELW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  // Per-lane state
  logic [LANES-1:0] busy_q;
  logic [1:0]       cnt_q [LANES];
  logic [1:0]       op_q  [LANES];
  logic [WIDTH-1:0] a_q   [LANES];
  logic [WIDTH-1:0] b_q   [LANES];

  // Lane decode and acceptance
  logic [LANES-1:0] sel_hit;
  logic [LANES-1:0] comp;
  logic [LANES-1:0] load;
  logic             lane_free;
  logic             accept;

  // Selected completing lane
  logic [1:0]       c_op;
  logic [WIDTH-1:0] c_a;
  logic [WIDTH-1:0] c_b;
  logic [SELW-1:0]  c_lane;
  logic             any_comp;

  // Arithmetic result
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;
  logic             lt_s;
  logic             lt_u;

  // Output registers
  logic             done_q;
  logic             err_q;
  logic [SELW-1:0]  lane_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;
  logic             ovf_q;

  // Out-of-range selects simply match no lane, so no array is ever indexed past LANES-1.
  always_comb begin
    sel_hit = '0;
    comp    = '0;
    for (int i = 0; i < LANES; i++) begin
      sel_hit[i] = (bus.lane_sel == SELW'(i));
      comp[i]    = busy_q[i] && (cnt_q[i] == 2'd0);
    end
  end

  // A lane finishing on this edge can take a new request on the same edge.
  assign lane_free = |(sel_hit & (~busy_q | comp));
  assign accept    = bus.start && lane_free;
  assign load      = accept ? sel_hit : '0;
  assign any_comp  = |comp;

  // Fixed latency and one accept per cycle guarantee at most one completing lane.
  always_comb begin
    c_op   = '0;
    c_a    = '0;
    c_b    = '0;
    c_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (comp[i]) begin
        c_op   = op_q[i];
        c_a    = a_q[i];
        c_b    = b_q[i];
        c_lane = SELW'(i);
      end
    end
  end

  assign lt_s = $signed(c_a) < $signed(c_b);
  assign lt_u = c_a < c_b;

  always_comb begin
    sum    = '0;
    r_res  = '0;
    r_cout = 1'b0;
    r_ovf  = 1'b0;
    case (c_op)
      OP_ADD: begin
        sum    = {1'b0, c_a} + {1'b0, c_b};
        r_res  = sum[WIDTH-1:0];
        r_cout = sum[WIDTH];
        r_ovf  = (c_a[WIDTH-1] == c_b[WIDTH-1]) && (r_res[WIDTH-1] != c_a[WIDTH-1]);
      end
      OP_SUB: begin
        // cout here is the inverted borrow of op1 - op2
        sum    = {1'b0, c_a} + {1'b0, ~c_b} + {{WIDTH{1'b0}}, 1'b1};
        r_res  = sum[WIDTH-1:0];
        r_cout = sum[WIDTH];
        r_ovf  = (c_a[WIDTH-1] != c_b[WIDTH-1]) && (r_res[WIDTH-1] != c_a[WIDTH-1]);
      end
      OP_SLT: begin
        r_res = {{(WIDTH-1){1'b0}}, lt_s};
      end
      default: begin
        r_res = {{(WIDTH-1){1'b0}}, lt_u};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i] <= 2'd0;
      end
      done_q <= 1'b0;
      err_q  <= 1'b0;
      lane_q <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      err_q  <= bus.start && !accept;
      done_q <= any_comp;
      if (any_comp) begin
        lane_q <= c_lane;
        res_q  <= r_res;
        cout_q <= r_cout;
        ovf_q  <= r_ovf;
      end
      for (int i = 0; i < LANES; i++) begin
        if (load[i]) begin
          busy_q[i] <= 1'b1;
          cnt_q[i]  <= CNT_INIT;
        end else if (comp[i]) begin
          busy_q[i] <= 1'b0;
        end else if (busy_q[i]) begin
          cnt_q[i] <= cnt_q[i] - 2'd1;
        end
      end
    end
  end

  // Operand storage needs no reset: it is only read while the lane is busy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (load[i]) begin
        op_q[i] <= bus.op;
        a_q[i]  <= bus.op1;
        b_q[i]  <= bus.op2;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.done      = done_q;
  assign bus.done_lane = lane_q;
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_sub_lanes.sv
// Scoreboard bench for add_sub_lanes: directed vectors, expectations queued at issue time.
module tb_add_sub_lanes;
  localparam int W   = 32;
  localparam int LN  = 3;
  localparam int LAT = 2;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] SLT  = 2'b10;
  localparam logic [1:0] SLTU = 2'b11;

  typedef struct {
    logic [1:0]  lane;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];
  int   err_due_q[$];
  exp_t mon_e;
  int   mon_d;

  add_sub_lanes_if #(.WIDTH(W), .LANES(LN)) bus ();

  add_sub_lanes #(.WIDTH(W), .LANES(LN), .LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done/err the DUT presents is matched against the queues.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done on lane %0d at cycle %0d expected none", bus.done_lane, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_lane", 32'(bus.done_lane), 32'(mon_e.lane));
        check("res", bus.res, mon_e.res);
        check("cout", 32'(bus.cout), 32'(mon_e.cout));
        check("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
        check("done_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
    if (bus.err === 1'b1) begin
      if (err_due_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_err: got err at cycle %0d expected none", cyc);
      end else begin
        mon_d = err_due_q.pop_front();
        check("err_cycle", 32'(cyc), 32'(mon_d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) tick();
  endtask

  // Drive one request across one edge; ok=1 queues a result, ok=0 queues an err.
  task automatic issue(input logic [1:0] sel, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b, input bit ok,
                       input logic [31:0] er, input logic ec, input logic eo);
    exp_t e;
    bus.start    = 1'b1;
    bus.lane_sel = sel;
    bus.op       = o;
    bus.op1      = a;
    bus.op2      = b;
    if (ok) begin
      e.lane = sel;
      e.res  = er;
      e.cout = ec;
      e.ovf  = eo;
      e.due  = cyc + 1 + LAT;
      exp_q.push_back(e);
    end else begin
      err_due_q.push_back(cyc + 1);
    end
    tick();
    // Scramble inputs so any late operand sampling shows up in the result.
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.op1   = $urandom;
    bus.op2   = $urandom;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_done_lane"}, 32'(bus.done_lane), 32'd0);
    check({tag, "_res"}, bus.res, 32'd0);
    check({tag, "_cout"}, 32'(bus.cout), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.lane_sel = '0;
    bus.op       = ADD;
    bus.op1      = '0;
    bus.op2      = '0;
    rst          = 1'b0;
    repeat (2) tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // Arithmetic vectors, back-to-back across lanes and reuse on completion edges
    issue(2'd0, ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    issue(2'd1, SUB,  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(2'd0, SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    issue(2'd2, SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    issue(2'd1, ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    issue(2'd2, SUB,  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    idle(4);
    issue(2'd0, SUB,  32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    issue(2'd1, SLT,  32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    issue(2'd2, SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    idle(4);

    // Second start to a busy lane is rejected; busy[0] reads 1,1,0
    issue(2'd0, ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
    check("dup_busy_a", 32'(bus.busy[0]), 32'd1);
    issue(2'd0, ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dup_busy_b", 32'(bus.busy[0]), 32'd1);
    idle(1);
    check("dup_busy_c", 32'(bus.busy[0]), 32'd0);
    idle(3);

    // Restart on the completion edge keeps busy[0] high
    issue(2'd0, SUB, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("re_busy_a", 32'(bus.busy[0]), 32'd1);
    idle(1);
    check("re_busy_b", 32'(bus.busy[0]), 32'd1);
    issue(2'd0, ADD, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
    check("re_busy_c", 32'(bus.busy[0]), 32'd1);
    idle(1);
    check("re_busy_d", 32'(bus.busy[0]), 32'd1);
    idle(1);
    check("re_busy_e", 32'(bus.busy[0]), 32'd0);
    idle(2);

    // Nonexistent lane
    issue(2'd3, ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 1'b0);
    check("oor_busy", 32'(bus.busy), 32'd0);
    idle(2);

    // Reset one cycle after start discards the operation and overrides a new start
    bus.start    = 1'b1;
    bus.lane_sel = 2'd1;
    bus.op       = ADD;
    bus.op1      = 32'h0000_0005;
    bus.op2      = 32'h0000_0006;
    tick();
    rst          = 1'b0;
    bus.lane_sel = 2'd0;
    tick();
    check_idle("midrst");
    bus.start = 1'b0;
    rst       = 1'b1;
    idle(6);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || err_due_q.size() != 0); i++) tick();
    check("pending_done", 32'(exp_q.size()), 32'd0);
    check("pending_err", 32'(err_due_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
